regfile_cmd_master: RTL and testbench

//   Command-side initiator for the 8-entry x WIDTH register file (2 async read ports, 1 sync write port, x0 hardwired 0).

---
 rtl/regfile_cmd_master.sv | 169 ++++++++++++++++
 tb/tb_regfile_cmd_master.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_cmd_master.sv
// Command sequencer for an 8-entry register file: READ/WRITE/COPY respond 2 cycles after accept, CLEAR after NREG.
// Responses are held in RESP until rsp_ready with unbounded backpressure; commands are accepted only in IDLE.
module regfile_cmd_master #(
    parameter int WIDTH = 4,
    parameter int NREG  = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [AW-1:0]    cmd_ra,
    input  logic [AW-1:0]    cmd_rb,
    input  logic [WIDTH-1:0] cmd_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data1,
    output logic [WIDTH-1:0] rsp_data2,
    output logic             rsp_err,
    output logic             busy,
    output logic [AW-1:0]    rf_raddr1,
    output logic [AW-1:0]    rf_raddr2,
    input  logic [WIDTH-1:0] rf_rdata1,
    input  logic [WIDTH-1:0] rf_rdata2,
    output logic             rf_we,
    output logic [AW-1:0]    rf_waddr,
    output logic [WIDTH-1:0] rf_wdata
);

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_COPY  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        EXEC  = 2'b01,
        SWEEP = 2'b10,
        RESP  = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [AW-1:0]    ra_q, ra_d;
    logic [AW-1:0]    rb_q, rb_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rsp1_q, rsp1_d;
    logic [WIDTH-1:0] rsp2_q, rsp2_d;
    logic             err_q, err_d;

    assign cmd_ready = rst_n && (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign rsp_data1 = rsp1_q;
    assign rsp_data2 = rsp2_q;
    assign rsp_err   = err_q;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        ra_d      = ra_q;
        rb_d      = rb_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        rsp1_d    = rsp1_q;
        rsp2_d    = rsp2_q;
        err_d     = err_q;
        rf_we     = 1'b0;
        rf_raddr1 = '0;
        rf_raddr2 = '0;
        rf_waddr  = '0;
        rf_wdata  = '0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    ra_d    = cmd_ra;
                    rb_d    = cmd_rb;
                    wdata_d = cmd_wdata;
                    if (cmd_op == OP_CLEAR) begin
                        cnt_d   = AW'(1);
                        state_d = SWEEP;
                    end else begin
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                rsp2_d  = '0;
                err_d   = 1'b0;
                state_d = RESP;
                case (op_q)
                    OP_READ: begin
                        rf_raddr1 = ra_q;
                        rf_raddr2 = rb_q;
                        rsp1_d    = rf_rdata1;
                        rsp2_d    = rf_rdata2;
                    end
                    OP_WRITE: begin
                        rf_we    = (ra_q != '0);
                        rf_waddr = ra_q;
                        rf_wdata = wdata_q;
                        rsp1_d   = wdata_q;
                        err_d    = (ra_q == '0);
                    end
                    OP_COPY: begin
                        // Source value flows straight from the async read port into the write port.
                        rf_raddr1 = ra_q;
                        rf_we     = (rb_q != '0);
                        rf_waddr  = rb_q;
                        rf_wdata  = rf_rdata1;
                        rsp1_d    = rf_rdata1;
                        err_d     = (rb_q == '0);
                    end
                    default: begin
                        rsp1_d = '0;
                    end
                endcase
            end
            SWEEP: begin
                rf_we    = 1'b1;
                rf_waddr = cnt_q;
                if (cnt_q == AW'(NREG - 1)) begin
                    rsp1_d  = '0;
                    rsp2_d  = '0;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rsp1_q  <= '0;
            rsp2_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rsp1_q  <= rsp1_d;
            rsp2_q  <= rsp2_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_regfile_cmd_master.sv
// Directed bench for regfile_cmd_master driving an 8x4 register file model on the rf_* ports.
module tb_regfile_cmd_master;
    localparam int WIDTH = 4;
    localparam int NREG  = 8;
    localparam int AW    = 3;

    localparam logic [1:0] RD = 2'b00;
    localparam logic [1:0] WR = 2'b01;
    localparam logic [1:0] CP = 2'b10;
    localparam logic [1:0] CL = 2'b11;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = '0;
    logic [AW-1:0]    cmd_ra = '0;
    logic [AW-1:0]    cmd_rb = '0;
    logic [WIDTH-1:0] cmd_wdata = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [WIDTH-1:0] rsp_data1, rsp_data2;
    logic             rsp_err, busy;
    logic [AW-1:0]    rf_raddr1, rf_raddr2, rf_waddr;
    logic [WIDTH-1:0] rf_rdata1, rf_rdata2, rf_wdata;
    logic             rf_we;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    regfile_cmd_master #(.WIDTH(WIDTH), .NREG(NREG), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data1(rsp_data1), .rsp_data2(rsp_data2), .rsp_err(rsp_err), .busy(busy),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    // Register file model: x0 reads as zero and ignores writes.
    logic [WIDTH-1:0] rf_mem [NREG];
    assign rf_rdata1 = (rf_raddr1 == '0) ? '0 : rf_mem[rf_raddr1];
    assign rf_rdata2 = (rf_raddr2 == '0) ? '0 : rf_mem[rf_raddr2];
    always @(posedge clk) begin
        if (rf_we && rf_waddr != '0) rf_mem[rf_waddr] <= rf_wdata;
    end

    int            we_total = 0;
    logic [AW-1:0]    we_a [64];
    logic [WIDTH-1:0] we_d [64];
    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            we_a[we_total[5:0]] = rf_waddr;
            we_d[we_total[5:0]] = rf_wdata;
            we_total++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic [1:0] op, input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                         input logic [WIDTH-1:0] wd);
        int n = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_ra = ra; cmd_rb = rb; cmd_wdata = wd;
        while (cmd_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL accept_timeout cmd_ready=%b want 1", cmd_ready);
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (rsp_valid !== 1'b1 && lat < 100);
    endtask

    task automatic ack();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                           input logic [WIDTH-1:0] wd, output int lat, output logic [WIDTH-1:0] d1,
                           output logic [WIDTH-1:0] d2, output logic err, output int wen, output int base);
        base = we_total;
        issue(op, ra, rb, wd);
        wait_rsp(lat);
        d1 = rsp_data1; d2 = rsp_data2; err = rsp_err;
        ack();
        wen = we_total - base;
    endtask

    task automatic test_reset();
        #12;
        n_cmp++;
        if ({cmd_ready, busy, rsp_valid, rf_we, rsp_err} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl got %b want 00000", {cmd_ready, busy, rsp_valid, rf_we, rsp_err});
        end
        n_cmp++;
        if ({rf_raddr1, rf_raddr2, rf_waddr, rf_wdata, rsp_data1, rsp_data2} !== '0) begin
            n_bad++;
            $display("FAIL reset_data got %h want 0", {rf_raddr1, rf_raddr2, rf_waddr, rf_wdata, rsp_data1, rsp_data2});
        end
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({cmd_ready, busy} !== 2'b10) begin
            n_bad++;
            $display("FAIL reset_release ready,busy got %b want 10", {cmd_ready, busy});
        end
    endtask

    task automatic test_write_read();
        int lat, wen, base;
        logic [WIDTH-1:0] d1, d2;
        logic err;
        run_cmd(WR, 3'd3, 3'd0, 4'hA, lat, d1, d2, err, wen, base);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL wr_lat got %0d want 2", lat); end
        n_cmp++; if (wen !== 1) begin n_bad++; $display("FAIL wr_we_cycles got %0d want 1", wen); end
        n_cmp++; if ({we_a[base[5:0]], we_d[base[5:0]]} !== {3'd3, 4'hA}) begin
            n_bad++; $display("FAIL wr_port got %h/%h want 3/a", we_a[base[5:0]], we_d[base[5:0]]); end
        n_cmp++; if ({d1, err} !== {4'hA, 1'b0}) begin
            n_bad++; $display("FAIL wr_rsp got %h err %b want a err 0", d1, err); end
        run_cmd(RD, 3'd3, 3'd0, 4'h0, lat, d1, d2, err, wen, base);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL rd_lat got %0d want 2", lat); end
        n_cmp++; if ({d1, d2, err} !== {4'hA, 4'h0, 1'b0}) begin
            n_bad++; $display("FAIL rd_rsp got %h %h err %b want a 0 err 0", d1, d2, err); end
        n_cmp++; if (wen !== 0) begin n_bad++; $display("FAIL rd_we_cycles got %0d want 0", wen); end
    endtask

    task automatic test_write_x0();
        int lat, wen, base;
        logic [WIDTH-1:0] d1, d2;
        logic err;
        run_cmd(WR, 3'd0, 3'd0, 4'hF, lat, d1, d2, err, wen, base);
        n_cmp++; if (wen !== 0) begin n_bad++; $display("FAIL x0_we_cycles got %0d want 0", wen); end
        n_cmp++; if ({d1, err} !== {4'hF, 1'b1}) begin
            n_bad++; $display("FAIL x0_rsp got %h err %b want f err 1", d1, err); end
        run_cmd(RD, 3'd0, 3'd0, 4'h0, lat, d1, d2, err, wen, base);
        n_cmp++; if ({d1, err} !== {4'h0, 1'b0}) begin
            n_bad++; $display("FAIL x0_read got %h err %b want 0 err 0", d1, err); end
    endtask

    task automatic test_copy();
        int lat, wen, base;
        logic [WIDTH-1:0] d1, d2;
        logic err;
        run_cmd(CP, 3'd3, 3'd5, 4'h0, lat, d1, d2, err, wen, base);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL cp_lat got %0d want 2", lat); end
        n_cmp++; if (wen !== 1) begin n_bad++; $display("FAIL cp_we_cycles got %0d want 1", wen); end
        n_cmp++; if ({we_a[base[5:0]], we_d[base[5:0]]} !== {3'd5, 4'hA}) begin
            n_bad++; $display("FAIL cp_port got %h/%h want 5/a", we_a[base[5:0]], we_d[base[5:0]]); end
        n_cmp++; if ({d1, d2, err} !== {4'hA, 4'h0, 1'b0}) begin
            n_bad++; $display("FAIL cp_rsp got %h %h err %b want a 0 err 0", d1, d2, err); end
        run_cmd(RD, 3'd5, 3'd3, 4'h0, lat, d1, d2, err, wen, base);
        n_cmp++; if ({d1, d2} !== {4'hA, 4'hA}) begin
            n_bad++; $display("FAIL cp_readback got %h %h want a a", d1, d2); end
        run_cmd(CP, 3'd3, 3'd0, 4'h0, lat, d1, d2, err, wen, base);
        n_cmp++; if ({wen[1:0], d1, err} !== {2'd0, 4'hA, 1'b1}) begin
            n_bad++; $display("FAIL cp_x0 got we %0d %h err %b want we 0 a err 1", wen, d1, err); end
    endtask

    task automatic test_clear();
        int lat, wen, base;
        logic [WIDTH-1:0] d1, d2;
        logic err;
        for (int i = 1; i < NREG; i++) run_cmd(WR, AW'(i), 3'd0, WIDTH'(i), lat, d1, d2, err, wen, base);
        run_cmd(RD, 3'd7, 3'd4, 4'h0, lat, d1, d2, err, wen, base);
        n_cmp++; if ({d1, d2} !== {4'h7, 4'h4}) begin
            n_bad++; $display("FAIL fill_read got %h %h want 7 4", d1, d2); end
        run_cmd(CL, 3'd0, 3'd0, 4'h0, lat, d1, d2, err, wen, base);
        n_cmp++; if (lat !== 8) begin n_bad++; $display("FAIL clr_lat got %0d want 8", lat); end
        n_cmp++; if (wen !== 7) begin n_bad++; $display("FAIL clr_we_cycles got %0d want 7", wen); end
        for (int i = 0; i < 7; i++) begin
            n_cmp++;
            if ({we_a[(base + i) % 64], we_d[(base + i) % 64]} !== {AW'(i + 1), 4'h0}) begin
                n_bad++;
                $display("FAIL clr_write%0d got %h/%h want %0d/0", i, we_a[(base + i) % 64], we_d[(base + i) % 64], i + 1);
            end
        end
        n_cmp++; if ({d1, d2, err} !== 9'b0) begin
            n_bad++; $display("FAIL clr_rsp got %h %h err %b want 0 0 err 0", d1, d2, err); end
        for (int i = 0; i < 4; i++) begin
            run_cmd(RD, AW'(2 * i + 1), AW'(2 * i + 2), 4'h0, lat, d1, d2, err, wen, base);
            n_cmp++;
            if ({d1, d2} !== 8'h00) begin
                n_bad++; $display("FAIL clr_read%0d got %h %h want 0 0", i, d1, d2);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat, wen, base;
        logic [WIDTH-1:0] d1, d2;
        logic err;
        run_cmd(WR, 3'd2, 3'd0, 4'h6, lat, d1, d2, err, wen, base);
        run_cmd(WR, 3'd4, 3'd0, 4'h9, lat, d1, d2, err, wen, base);
        issue(RD, 3'd2, 3'd4, 4'h0);
        wait_rsp(lat);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL bp_lat got %0d want 2", lat); end
        cmd_valid = 1'b1; cmd_op = WR; cmd_ra = 3'd1; cmd_rb = 3'd0; cmd_wdata = 4'h3;
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if ({rsp_valid, rsp_data1, rsp_data2, cmd_ready} !== {1'b1, 4'h6, 4'h9, 1'b0}) begin
                n_bad++;
                $display("FAIL bp_hold%0d got v%b %h %h rdy%b want v1 6 9 rdy0", i, rsp_valid, rsp_data1, rsp_data2, cmd_ready);
            end
            @(negedge clk);
        end
        ack();
        @(negedge clk);
        n_cmp++;
        if ({cmd_ready, busy} !== 2'b10) begin
            n_bad++; $display("FAIL bp_bubble ready,busy got %b want 10", {cmd_ready, busy});
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL bp_taken busy got %b want 1", busy); end
        wait_rsp(lat);
        d1 = rsp_data1; err = rsp_err;
        ack();
        n_cmp++; if ({lat[3:0], d1, err} !== {4'd2, 4'h3, 1'b0}) begin
            n_bad++; $display("FAIL bp_second got lat %0d %h err %b want lat 2 3 err 0", lat, d1, err); end
        run_cmd(RD, 3'd1, 3'd2, 4'h0, lat, d1, d2, err, wen, base);
        n_cmp++; if ({d1, d2} !== {4'h3, 4'h6}) begin
            n_bad++; $display("FAIL bp_readback got %h %h want 3 6", d1, d2); end
    endtask

    task automatic test_reset_abort();
        int lat, wen, base, b;
        logic [WIDTH-1:0] d1, d2;
        logic err;
        run_cmd(WR, 3'd6, 3'd0, 4'h5, lat, d1, d2, err, wen, base);
        b = we_total;
        issue(CL, 3'd0, 3'd0, 4'h0);
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if ({rf_we, rf_waddr} !== {1'b1, 3'd4}) begin
            n_bad++; $display("FAIL abort_pre got we%b addr %0d want we1 addr 4", rf_we, rf_waddr); end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({rf_we, busy, cmd_ready, rsp_valid, rf_waddr, rf_wdata} !== '0) begin
            n_bad++;
            $display("FAIL abort_outputs got we%b busy%b rdy%b v%b addr %0d",
                     rf_we, busy, cmd_ready, rsp_valid, rf_waddr);
        end
        n_cmp++; if (we_total - b !== 3) begin n_bad++; $display("FAIL abort_writes got %0d want 3", we_total - b); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++;
            if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL abort_no_rsp%0d got %b want 0", i, rsp_valid); end
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL abort_ready got %b want 1", cmd_ready); end
        run_cmd(RD, 3'd6, 3'd3, 4'h0, lat, d1, d2, err, wen, base);
        n_cmp++; if ({d1, d2} !== {4'h5, 4'h0}) begin
            n_bad++; $display("FAIL abort_partial got %h %h want 5 0", d1, d2); end
        run_cmd(WR, 3'd2, 3'd0, 4'hC, lat, d1, d2, err, wen, base);
        run_cmd(RD, 3'd2, 3'd6, 4'h0, lat, d1, d2, err, wen, base);
        n_cmp++; if ({lat[3:0], d1, d2} !== {4'd2, 4'hC, 4'h5}) begin
            n_bad++; $display("FAIL abort_recover got lat %0d %h %h want lat 2 c 5", lat, d1, d2); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_write_x0();
        test_copy();
        test_clear();
        test_backpressure();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
